// File: rtl/text_cell_buffer.sv
// Character-cell store for the VGA text terminal: host byte stream in, per-pixel character code out.
// Handles CR/LF/BS/FF, cursor wrap and hardware scrolling through a rotating top_row.
module text_cell_buffer #(
    parameter int         COLS  = 32,
    parameter int         ROWS  = 16,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] vid_hpos,
    input  logic [8:0] vid_vpos,
    input  logic       vid_display_on,
    output logic [7:0] vid_char,
    output logic [2:0] vid_xofs,
    output logic [3:0] vid_yofs,
    output logic       vid_on,
    output logic [5:0] cursor_col,
    output logic [4:0] cursor_row,
    output logic [1:0] dbg_state
);

    // Host handshake: a byte transfers on a rising clk edge where in_valid && in_ready;
    // in_ready depends only on FSM state, and in_data must be held while in_valid waits.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_SCROLL = 2'd2
    } state_t;

    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    // Compare-and-subtract so ROWS need not be a power of two.
    function automatic logic [4:0] add_mod(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'(ROWS))
            s = s - 6'(ROWS);
        return s[4:0];
    endfunction

    state_t      state, state_nxt;
    logic [4:0]  top_row;
    logic [4:0]  fill_row;
    logic [5:0]  fill_col;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;

    logic take, is_ff, is_lf, is_cr, is_bs, is_print;
    logic at_last_row, at_last_col, fill_last_col, fill_last_row;

    assign take          = in_valid && in_ready;
    assign is_ff         = (in_data == 8'h0C);
    assign is_lf         = (in_data == 8'h0A);
    assign is_cr         = (in_data == 8'h0D);
    assign is_bs         = (in_data == 8'h08);
    assign is_print      = (in_data >= 8'h20);
    assign at_last_row   = (cursor_row == LAST_ROW);
    assign at_last_col   = (cursor_col == LAST_COL);
    assign fill_last_col = (fill_col == LAST_COL);
    assign fill_last_row = (fill_row == LAST_ROW);
    assign dbg_state     = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_CLEAR;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (take) begin
                    if (is_ff)
                        state_nxt = S_CLEAR;
                    else if (at_last_row && (is_lf || (is_print && at_last_col)))
                        state_nxt = S_SCROLL;
                end
            end
            S_CLEAR:  if (fill_last_col && fill_last_row) state_nxt = S_IDLE;
            S_SCROLL: if (fill_last_col) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = {fill_row, fill_col};
        wr_data  = BLANK;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (take && is_print) begin
                    wr_en   = 1'b1;
                    wr_addr = {add_mod(cursor_row, top_row), cursor_col};
                    wr_data = in_data;
                end
            end
            S_CLEAR, S_SCROLL: wr_en = 1'b1;
            default: ;
        endcase
    end

    // CLEAR walks physical rows directly; every row is blanked regardless of top_row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cursor_col <= '0;
            cursor_row <= '0;
            top_row    <= '0;
            fill_row   <= '0;
            fill_col   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take) begin
                        if (is_ff) begin
                            fill_row <= '0;
                            fill_col <= '0;
                        end else if (is_cr) begin
                            cursor_col <= '0;
                        end else if (is_bs) begin
                            if (cursor_col != 6'd0)
                                cursor_col <= cursor_col - 6'd1;
                        end else if (is_lf || (is_print && at_last_col)) begin
                            if (is_print)
                                cursor_col <= '0;
                            if (!at_last_row) begin
                                cursor_row <= cursor_row + 5'd1;
                            end else begin
                                // Old top line becomes the new bottom line and gets blanked.
                                fill_row <= top_row;
                                fill_col <= '0;
                                top_row  <= add_mod(top_row, 5'd1);
                            end
                        end else if (is_print) begin
                            cursor_col <= cursor_col + 6'd1;
                        end
                    end
                end
                S_CLEAR: begin
                    if (fill_last_col) begin
                        fill_col <= '0;
                        fill_row <= fill_row + 5'd1;
                        if (fill_last_row) begin
                            cursor_col <= '0;
                            cursor_row <= '0;
                            top_row    <= '0;
                        end
                    end else begin
                        fill_col <= fill_col + 6'd1;
                    end
                end
                S_SCROLL: fill_col <= fill_col + 6'd1;
                default: ;
            endcase
        end
    end

    logic [7:0]  mem [0:2047];
    logic [7:0]  rd_q;
    logic [5:0]  v_col;
    logic [4:0]  v_row;
    logic        v_in_range;
    logic [10:0] rd_addr;
    logic        in_range_q;
    logic        disp_q;

    assign v_col      = vid_hpos[8:3];
    assign v_row      = vid_vpos[8:4];
    assign v_in_range = ({1'b0, v_col} < 7'(COLS)) && ({1'b0, v_row} < 6'(ROWS));
    assign rd_addr    = {add_mod(v_row, top_row), v_col};

    // Unreset RAM; a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_range_q <= 1'b0;
            disp_q     <= 1'b0;
            vid_xofs   <= '0;
            vid_yofs   <= '0;
        end else begin
            in_range_q <= v_in_range;
            disp_q     <= vid_display_on;
            vid_xofs   <= vid_hpos[2:0];
            vid_yofs   <= vid_vpos[3:0];
        end
    end

    assign vid_char = rd_q & {8{in_range_q}};
    assign vid_on   = disp_q && in_range_q;

endmodule
